systolic_matmul_mkn: RTL and testbench
======================================

# systolic_matmul_mkn

Parametrised output-stationary systolic multiplier computing C = A·B (or C += A·B) for a rectangular M×K by K×N operand pair, with per-job signed/unsigned selection and a valid/ready input handshake. It is the general successor to the square fixed-size multiplier in the matrix-multiply datapath. It sits between the operand staging buffers and the result writeback logic, and runs one job at a time.

## Interface
- M, 3: rows of A and C
- K, 3: inner dimension (columns of A, rows of B)
- N, 3: columns of B and C
- DATA_W, 4: operand element width
- ACC_W, 16: accumulator and result element width; requires ACC_W >= 2*DATA_W
- clock  in  1  single clock, rising edge
- nreset  in  1  asynchronous, active-low reset
- valid_i  in  1  job request; qualifies a_input, b_input, signed_i, accumulate_i
- a_input  in  [DATA_W-1:0] x [M][K]  operand A
- b_input  in  [DATA_W-1:0] x [K][N]  operand B
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned
- accumulate_i  in  1  1 = add into the previous C, 0 = clear the PEs before the job
- in_ready_o  out  1  block can accept a job this cycle
- done_o  out  1  one-cycle pulse: c_output updated
- busy_o  out  1  a job is in flight (LOAD or COMPUTE)
- c_output  out  [ACC_W-1:0] x [M][N]  result; held until the next done_o

## Operation
- Handshake: a job is accepted at a rising edge where valid_i && in_ready_o. At acceptance, a_input, b_input, signed_i and accumulate_i are latched. Later input changes have no effect on the job in flight.
- in_ready_o = 1 in IDLE and DONE only. valid_i in any other state is ignored and is not queued.
- FSM:
  - IDLE -> LOAD on accept.
  - LOAD -> COMPUTE unconditionally.
  - COMPUTE -> DONE when the step counter reaches M+N+K-3.
  - DONE -> LOAD on accept, else IDLE.
- LOAD (1 cycle): clears all PE accumulators if the latched accumulate flag is 0, otherwise keeps them. Resets the step counter t to 0.
- COMPUTE (M+N+K-2 cycles, t = 0..M+N+K-3): skewed feed.
  - Row i of A enters the left edge delayed by i cycles.
  - Column j of B enters the top edge delayed by j cycles.
  - PE(i,j) at step t multiplies A[i][t-i-j] by B[t-i-j][j] when 0 <= t-i-j < K; otherwise it sees zero operands.
  - Each PE forwards A right and B down through one register stage.
- Arithmetic:
  - Operands are sign-extended (signed) or zero-extended (unsigned) to ACC_W before multiplication.
  - Products and sums wrap modulo 2^ACC_W; there is no saturation.
- DONE (1 cycle): done_o = 1. c_output was loaded from the PE accumulators on the edge entering DONE.
- The PE accumulators are not cleared after DONE, so that a following accumulate_i = 1 job adds to them.

## Timing
- Reset values (asynchronous, while nreset = 0):
  - state IDLE
  - in_ready_o = 1, done_o = 0, busy_o = 0
  - c_output all 0, PE accumulators all 0, latched operands 0
- Latency: acceptance at edge E0 gives LOAD in cycle 1, COMPUTE in cycles 2 .. M+N+K-1, and DONE / done_o in cycle M+N+K.
- Back-to-back: an accept in DONE gives a job period of M+N+K cycles with no bubble. done_o is never high for two consecutive cycles.
- busy_o = 1 exactly in LOAD and COMPUTE.
- Reset mid-job:
  - aborts immediately; no done_o is produced.
  - c_output returns to 0 and the accumulators clear.
  - The first edge after release sees IDLE with in_ready_o = 1.
- Degenerate sizes:
  - K = 1 is legal.
  - M = N = K = 1 gives a COMPUTE length of 1 cycle and a latency of 3.

## Test plan
- Defaults except M=2, K=3, N=2, unsigned, A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]] -> done_o exactly 7 cycles after accept, c_output=[[58,64],[139,154]].
- Defaults, A all 4'h8, B all 4'h7, signed_i=1 -> every C = 16'hFF58 (-168). Repeat with signed_i=0 -> every C = 16'h00A8 (168).
- A=identity, B all 2, accumulate_i=0 -> all C=2. Accepted again in DONE with accumulate_i=1 and the same operands -> next done_o after 9 cycles, all C=4.
- ACC_W=8, unsigned, A and B all 15 -> every C = 163 (675 mod 256, wrap without saturation).
- Pulse valid_i with different operands during COMPUTE -> in_ready_o=0, the request is ignored, c_output reflects only the original job, and exactly one done_o.
- Assert nreset in the 4th COMPUTE cycle -> outputs immediately at reset values, no done_o. After release, a new job completes correctly, with accumulate_i=1 treated as adding to 0.

Source files
------------

// File: rtl/systolic_matmul_mkn.sv
// systolic_matmul_mkn: output-stationary M x K by K x N systolic multiplier.
// Skewed operand feed, per-PE accumulators, valid/ready job handshake.
module systolic_matmul_mkn #(
  parameter int M      = 3,
  parameter int K      = 3,
  parameter int N      = 3,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic                             clock,
  input  logic                             nreset,
  input  logic                             valid_i,
  input  logic [M-1:0][K-1:0][DATA_W-1:0]  a_input,
  input  logic [K-1:0][N-1:0][DATA_W-1:0]  b_input,
  input  logic                             signed_i,
  input  logic                             accumulate_i,
  output logic                             in_ready_o,
  output logic                             done_o,
  output logic                             busy_o,
  output logic [M-1:0][N-1:0][ACC_W-1:0]   c_output
);

  localparam int TW = $clog2(M + N + K);
  localparam logic [TW-1:0] T_LAST = TW'(M + N + K - 3);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMP,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] t;
  logic          last;
  logic          accept;

  logic [M-1:0][K-1:0][DATA_W-1:0] a_lat;
  logic [K-1:0][N-1:0][DATA_W-1:0] b_lat;
  logic                            sgn_lat;
  logic                            acc_lat;

  logic [DATA_W-1:0] a_edge [M];
  logic [DATA_W-1:0] b_edge [N];
  logic [DATA_W-1:0] a_pe   [M][N];
  logic [DATA_W-1:0] b_pe   [M][N];
  logic [DATA_W-1:0] a_reg  [M][N];
  logic [DATA_W-1:0] b_reg  [M][N];
  logic [ACC_W-1:0]  acc    [M][N];
  logic [ACC_W-1:0]  acc_nxt[M][N];

  function automatic logic [ACC_W-1:0] ext(
    input logic [DATA_W-1:0] x,
    input logic              s
  );
    ext = {{(ACC_W-DATA_W){s & x[DATA_W-1]}}, x};
  endfunction

  assign accept = valid_i && in_ready_o;
  assign last   = (state == COMP) && (t == T_LAST);

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    state_nxt  = state;
    in_ready_o = 1'b0;
    done_o     = 1'b0;
    busy_o     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (valid_i) state_nxt = LOAD;
      end
      LOAD: begin
        busy_o    = 1'b1;
        state_nxt = COMP;
      end
      COMP: begin
        busy_o = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        in_ready_o = 1'b1;
        state_nxt  = valid_i ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skewed edge feed: row i / column j enter delayed by i / j steps
  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_edge[i] = '0;
      for (int k = 0; k < K; k++)
        if (32'(t) == 32'(i + k)) a_edge[i] = a_lat[i][k];
    end
    for (int j = 0; j < N; j++) begin
      b_edge[j] = '0;
      for (int k = 0; k < K; k++)
        if (32'(t) == 32'(j + k)) b_edge[j] = b_lat[k][j];
    end
  end

  // PE operand routing and multiply-accumulate
  always_comb begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        a_pe[i][j] = (j == 0) ? a_edge[i]
                   : a_reg[i][(j == 0) ? 0 : j - 1];
        b_pe[i][j] = (i == 0) ? b_edge[j]
                   : b_reg[(i == 0) ? 0 : i - 1][j];
        acc_nxt[i][j] = acc[i][j]
                      + ext(a_pe[i][j], sgn_lat)
                      * ext(b_pe[i][j], sgn_lat);
      end
    end
  end

  // PE accumulators and operand forwarding registers
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
    end else if (state == LOAD) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) begin
          if (!acc_lat) acc[i][j] <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
    end else if (state == COMP) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= acc_nxt[i][j];
          a_reg[i][j] <= a_pe[i][j];
          b_reg[i][j] <= b_pe[i][j];
        end
    end
  end

  // Job latch, step counter and result capture
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      a_lat    <= '0;
      b_lat    <= '0;
      sgn_lat  <= 1'b0;
      acc_lat  <= 1'b0;
      t        <= '0;
      c_output <= '0;
    end else begin
      if (accept) begin
        a_lat   <= a_input;
        b_lat   <= b_input;
        sgn_lat <= signed_i;
        acc_lat <= accumulate_i;
      end
      if (state == LOAD)      t <= '0;
      else if (state == COMP) t <= t + 1'b1;
      if (last)
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            c_output[i][j] <= acc_nxt[i][j];
    end
  end

endmodule

// File: tb/tb_systolic_matmul_mkn.sv
// tb_systolic_matmul_mkn: directed checks of systolic_matmul_mkn.
// Four instances cover 2x3x2, 3x3x3, 8-bit accumulators and 1x1x1.
module tb_systolic_matmul_mkn;

  logic clock;
  logic nreset;

  logic v0, s0, ac0, rdy0, dn0, bz0;
  logic [1:0][2:0][3:0]  a0;
  logic [2:0][1:0][3:0]  b0;
  logic [1:0][1:0][15:0] c0, e0;

  logic v1, s1, ac1, rdy1, dn1, bz1;
  logic [2:0][2:0][3:0]  a1, b1;
  logic [2:0][2:0][15:0] c1, e1;

  logic v2, s2, ac2, rdy2, dn2, bz2;
  logic [2:0][2:0][3:0]  a2, b2;
  logic [2:0][2:0][7:0]  c2, e2;

  logic v3, s3, ac3, rdy3, dn3, bz3;
  logic [0:0][0:0][3:0]  a3, b3;
  logic [0:0][0:0][15:0] c3;

  int total;
  int passed;
  int failed;
  int n;
  int ndone;

  systolic_matmul_mkn #(.M(2), .K(3), .N(2)) u0 (
    .clock(clock), .nreset(nreset), .valid_i(v0),
    .a_input(a0), .b_input(b0), .signed_i(s0),
    .accumulate_i(ac0), .in_ready_o(rdy0), .done_o(dn0),
    .busy_o(bz0), .c_output(c0)
  );

  systolic_matmul_mkn u1 (
    .clock(clock), .nreset(nreset), .valid_i(v1),
    .a_input(a1), .b_input(b1), .signed_i(s1),
    .accumulate_i(ac1), .in_ready_o(rdy1), .done_o(dn1),
    .busy_o(bz1), .c_output(c1)
  );

  systolic_matmul_mkn #(.ACC_W(8)) u2 (
    .clock(clock), .nreset(nreset), .valid_i(v2),
    .a_input(a2), .b_input(b2), .signed_i(s2),
    .accumulate_i(ac2), .in_ready_o(rdy2), .done_o(dn2),
    .busy_o(bz2), .c_output(c2)
  );

  systolic_matmul_mkn #(.M(1), .K(1), .N(1)) u3 (
    .clock(clock), .nreset(nreset), .valid_i(v3),
    .a_input(a3), .b_input(b3), .signed_i(s3),
    .accumulate_i(ac3), .in_ready_o(rdy3), .done_o(dn3),
    .busy_o(bz3), .c_output(c3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts edges (the accept edge included) until done_o of one unit
  task automatic wait_done(input int which, output int cyc);
    logic d;
    d   = 1'b0;
    cyc = 0;
    while (!d && cyc < 40) begin
      tick();
      v0 = 1'b0;
      v1 = 1'b0;
      v2 = 1'b0;
      v3 = 1'b0;
      cyc++;
      case (which)
        0:       d = dn0;
        1:       d = dn1;
        2:       d = dn2;
        default: d = dn3;
      endcase
    end
  endtask

  function automatic logic [2:0][2:0][3:0] all4(input logic [3:0] v);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) all4[i][j] = v;
  endfunction

  function automatic logic [2:0][2:0][3:0] ident4();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) ident4[i][j] = (i == j) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [2:0][2:0][15:0] all16(input logic [15:0] v);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) all16[i][j] = v;
  endfunction

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    {v0, s0, ac0, v1, s1, ac1} = '0;
    {v2, s2, ac2, v3, s3, ac3} = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    nreset = 1'b1;
    #2 nreset = 1'b0;
    #1;
    chk("rst_ready", 256'(rdy1), 256'(1'b1));
    chk("rst_done", 256'(dn1), 256'(1'b0));
    chk("rst_busy", 256'(bz1), 256'(1'b0));
    chk("rst_c", 256'(c1), 256'(0));
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    tick();

    // 2x3x2 unsigned example
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) a0[i][k] = 4'(i * 3 + k + 1);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 2; j++) b0[k][j] = 4'(k * 2 + j + 7);
    e0[0][0] = 16'd58;
    e0[0][1] = 16'd64;
    e0[1][0] = 16'd139;
    e0[1][1] = 16'd154;
    v0 = 1'b1;
    chk("ready_idle", 256'(rdy0), 256'(1'b1));
    wait_done(0, n);
    chk("lat_2x3x2", 256'(n), 256'(7));
    chk("c_2x3x2", 256'(c0), 256'(e0));

    // 8-bit accumulators wrap: 3*225 = 675 -> 163
    a2 = all4(4'hF);
    b2 = all4(4'hF);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) e2[i][j] = 8'd163;
    v2 = 1'b1;
    wait_done(2, n);
    chk("lat_acc8", 256'(n), 256'(9));
    chk("c_acc8_wrap", 256'(c2), 256'(e2));

    // 1x1x1: latency 3, then back-to-back signed job
    a3[0][0] = 4'd5;
    b3[0][0] = 4'd3;
    v3 = 1'b1;
    wait_done(3, n);
    chk("lat_1x1x1", 256'(n), 256'(3));
    chk("c_1x1x1", 256'(c3), 256'(16'd15));
    a3[0][0] = 4'hF;
    b3[0][0] = 4'h2;
    s3 = 1'b1;
    v3 = 1'b1;
    wait_done(3, n);
    chk("lat_1x1x1_b2b", 256'(n), 256'(3));
    chk("c_1x1x1_signed", 256'(c3), 256'(16'hFFFE));

    // Signed and unsigned 8 x 7 over K = 3
    a1 = all4(4'h8);
    b1 = all4(4'h7);
    s1 = 1'b1;
    v1 = 1'b1;
    wait_done(1, n);
    chk("lat_3x3x3", 256'(n), 256'(9));
    chk("c_signed", 256'(c1), 256'(all16(16'hFF58)));
    s1 = 1'b0;
    v1 = 1'b1;
    wait_done(1, n);
    chk("c_unsigned", 256'(c1), 256'(all16(16'h00A8)));

    // Identity times all-2, then accumulate back-to-back
    a1 = ident4();
    b1 = all4(4'd2);
    v1 = 1'b1;
    wait_done(1, n);
    chk("c_ident", 256'(c1), 256'(all16(16'd2)));
    chk("ready_in_done", 256'(rdy1), 256'(1'b1));
    ac1 = 1'b1;
    v1  = 1'b1;
    wait_done(1, n);
    chk("b2b_period", 256'(n), 256'(9));
    chk("c_accum", 256'(c1), 256'(all16(16'd4)));
    tick();
    chk("done_single", 256'(dn1), 256'(1'b0));
    chk("c_held", 256'(c1), 256'(all16(16'd4)));

    // Request during COMPUTE is ignored
    a1  = ident4();
    b1  = all4(4'd1);
    ac1 = 1'b0;
    v1  = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    tick();
    chk("busy_compute", 256'(bz1), 256'(1'b1));
    chk("ready_compute", 256'(rdy1), 256'(1'b0));
    a1  = all4(4'hF);
    b1  = all4(4'hF);
    ac1 = 1'b1;
    v1  = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      v1 = 1'b0;
      if (dn1) ndone++;
    end
    chk("one_done", 256'(ndone), 256'(1));
    chk("c_ignore", 256'(c1), 256'(all16(16'd1)));
    chk("idle_after", 256'({rdy1, bz1}), 256'(2'b10));

    // Reset in the 4th COMPUTE cycle
    a1  = all4(4'd1);
    b1  = all4(4'd1);
    ac1 = 1'b0;
    v1  = 1'b1;
    tick();
    v1 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    nreset = 1'b0;
    #1;
    chk("midrst_c", 256'(c1), 256'(0));
    chk("midrst_stat", 256'({rdy1, dn1, bz1}), 256'(3'b100));
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (dn1) ndone++;
    end
    chk("midrst_no_done", 256'(ndone), 256'(0));
    @(negedge clock);
    nreset = 1'b1;
    chk("ready_after_rst", 256'(rdy1), 256'(1'b1));
    a1 = ident4();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        b1[k][j] = 4'(k * 3 + j + 1);
        e1[k][j] = 16'(k * 3 + j + 1);
      end
    ac1 = 1'b1;
    v1  = 1'b1;
    wait_done(1, n);
    chk("lat_after_rst", 256'(n), 256'(9));
    chk("c_after_rst", 256'(c1), 256'(e1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
